// File: rtl/count_event_monitor.sv
// count_event_monitor: detects counter wrap/threshold events and queues them in a FIFO
module count_event_monitor #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] thresh,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type,
  output logic [WIDTH-1:0] evt_count,
  output logic [7:0]       wrap_total,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             prev_mode_q, prev_mode_d;
  logic             prev_ok_q, prev_ok_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             drop_q, drop_d;
  logic [WIDTH+1:0] mem_q [DEPTH];
  logic             ovf, unf, thr, push, pop, wr_en;
  logic [1:0]       ev_type;
  always_comb begin
    ovf          = prev_ok_q && prev_mode_q && prev_count_q == '1 && count == '0;
    unf          = prev_ok_q && !prev_mode_q && prev_count_q == '0 && count == '1;
    thr          = prev_ok_q && count == thresh && prev_count_q != thresh;
    ev_type      = ovf ? 2'b01 : (unf ? 2'b10 : 2'b11);
    push         = ovf || unf || thr;
    pop          = evt_valid && evt_ready;
    // a full FIFO still accepts when the head leaves on the same edge
    wr_en        = push && (occ_q != OW'(DEPTH) || pop);
    wr_ptr_d     = wr_ptr_q + AW'(wr_en);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    occ_d        = occ_q + OW'(wr_en) - OW'(pop);
    wrap_d       = ((ovf || unf) && wrap_q != 8'hff) ? wrap_q + 8'd1 : wrap_q;
    drop_d       = drop_q || (push && !wr_en);
    prev_count_d = count;
    prev_mode_d  = mode;
    prev_ok_d    = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_count_q <= '0;
      prev_mode_q  <= 1'b0;
      prev_ok_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      wrap_q       <= '0;
      drop_q       <= 1'b0;
    end else begin
      prev_count_q <= prev_count_d;
      prev_mode_q  <= prev_mode_d;
      prev_ok_q    <= prev_ok_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      wrap_q       <= wrap_d;
      drop_q       <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ev_type, count};
  end
  assign evt_valid  = occ_q != '0;
  assign evt_type   = evt_valid ? mem_q[rd_ptr_q][WIDTH+1:WIDTH] : 2'b00;
  assign evt_count  = evt_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
  assign wrap_total = wrap_q;
  assign drop       = drop_q;
endmodule

// File: tb/tb_count_event_monitor.sv
// tb_count_event_monitor: directed and randomized checks against a queue-based event model
module tb_count_event_monitor;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] count = 4'd0;
  logic [3:0] thresh = 4'd7;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_type;
  logic [3:0] evt_count;
  logic [7:0] wrap_total;
  logic       drop;
  int n_chk = 0;
  int n_pass = 0;
  logic [5:0] m_q [$];
  int         m_wrap;
  bit         m_drop, m_ok, m_pmode;
  logic [3:0] m_prev;

  count_event_monitor #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .count(count), .thresh(thresh),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type),
    .evt_count(evt_count), .wrap_total(wrap_total), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_q.delete();
    m_wrap = 0;
    m_drop = 0;
    m_ok = 0;
    m_pmode = 0;
    m_prev = 4'd0;
  endtask

  task automatic model_step();
    int  ev;
    bit  pop;
    ev = 0;
    pop = m_q.size() > 0 && evt_ready;
    if (m_ok) begin
      if (m_pmode && m_prev == 4'd15 && count == 4'd0) ev = 1;
      else if (!m_pmode && m_prev == 4'd0 && count == 4'd15) ev = 2;
      else if (count == thresh && m_prev != thresh) ev = 3;
    end
    if ((ev == 1 || ev == 2) && m_wrap < 255) m_wrap++;
    if (pop) void'(m_q.pop_front());
    if (ev != 0) begin
      if (m_q.size() < 4) m_q.push_back({ev[1:0], count});
      else m_drop = 1;
    end
    m_prev = count;
    m_pmode = mode;
    m_ok = 1;
  endtask

  task automatic tick(input logic [3:0] c);
    count = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    #3;
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", evt_valid); else n_pass++;
    n_chk++; if (evt_type !== 2'b00) $display("FAIL rst_type got %0b want 00", evt_type); else n_pass++;
    n_chk++; if (evt_count !== 4'd0) $display("FAIL rst_count got %0d want 0", evt_count); else n_pass++;
    n_chk++; if (wrap_total !== 8'd0) $display("FAIL rst_wrap got %0d want 0", wrap_total); else n_pass++;
    n_chk++; if (drop !== 1'b0) $display("FAIL rst_drop got %0b want 0", drop); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    mode = 1'b0;
    evt_ready = 1'b0;
    tick(4'd15);
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL rst_first_edge got %0b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_up_wrap();
    do_reset();
    mode = 1'b1; evt_ready = 1'b1; thresh = 4'd7;
    tick(4'd14);
    tick(4'd15);
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL up_pre got %0b want 0", evt_valid); else n_pass++;
    tick(4'd0);
    n_chk++; if (evt_valid !== 1'b1) $display("FAIL up_valid got %0b want 1", evt_valid); else n_pass++;
    n_chk++; if (evt_type !== 2'b01) $display("FAIL up_type got %0b want 01", evt_type); else n_pass++;
    n_chk++; if (evt_count !== 4'd0) $display("FAIL up_count got %0d want 0", evt_count); else n_pass++;
    n_chk++; if (wrap_total !== 8'd1) $display("FAIL up_wrap got %0d want 1", wrap_total); else n_pass++;
    tick(4'd1);
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL up_popped got %0b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_down_wrap();
    do_reset();
    mode = 1'b0; evt_ready = 1'b0; thresh = 4'd7;
    tick(4'd1);
    tick(4'd0);
    tick(4'd15);
    n_chk++; if (evt_valid !== 1'b1) $display("FAIL dn_valid got %0b want 1", evt_valid); else n_pass++;
    n_chk++; if (evt_type !== 2'b10) $display("FAIL dn_type got %0b want 10", evt_type); else n_pass++;
    n_chk++; if (evt_count !== 4'd15) $display("FAIL dn_count got %0d want 15", evt_count); else n_pass++;
    n_chk++; if (wrap_total !== 8'd1) $display("FAIL dn_wrap got %0d want 1", wrap_total); else n_pass++;
  endtask

  task automatic test_threshold();
    do_reset();
    mode = 1'b1; evt_ready = 1'b0; thresh = 4'd7;
    tick(4'd6);
    tick(4'd7);
    tick(4'd7);
    tick(4'd8);
    n_chk++; if (evt_valid !== 1'b1) $display("FAIL thr_valid got %0b want 1", evt_valid); else n_pass++;
    n_chk++; if (evt_type !== 2'b11) $display("FAIL thr_type got %0b want 11", evt_type); else n_pass++;
    n_chk++; if (evt_count !== 4'd7) $display("FAIL thr_count got %0d want 7", evt_count); else n_pass++;
    evt_ready = 1'b1;
    tick(4'd9);
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL thr_single got %0b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int pops;
    do_reset();
    mode = 1'b1; evt_ready = 1'b0; thresh = 4'd7;
    tick(4'd15);
    for (int i = 0; i < 5; i++) begin
      tick(4'd0);
      if (i < 4) tick(4'd15);
    end
    n_chk++; if (drop !== 1'b1) $display("FAIL bp_drop got %0b want 1", drop); else n_pass++;
    n_chk++; if (wrap_total !== 8'd5) $display("FAIL bp_wrap got %0d want 5", wrap_total); else n_pass++;
    n_chk++; if ({evt_valid, evt_type, evt_count} !== 7'b1_01_0000) $display("FAIL bp_head got %b want 1010000", {evt_valid, evt_type, evt_count}); else n_pass++;
    evt_ready = 1'b1;
    pops = 0;
    while (evt_valid === 1'b1 && pops < 10) begin
      n_chk++; if (evt_type !== 2'b01) $display("FAIL bp_pop_type got %0b want 01", evt_type); else n_pass++;
      tick(4'd0);
      pops++;
    end
    n_chk++; if (pops != 4) $display("FAIL bp_pops got %0d want 4", pops); else n_pass++;
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", evt_valid); else n_pass++;
    n_chk++; if (drop !== 1'b1) $display("FAIL bp_sticky got %0b want 1", drop); else n_pass++;
  endtask

  task automatic test_full_pop();
    int pops;
    do_reset();
    mode = 1'b1; evt_ready = 1'b0; thresh = 4'd7;
    tick(4'd15);
    for (int i = 0; i < 4; i++) begin
      tick(4'd0);
      tick(4'd15);
    end
    evt_ready = 1'b1;
    tick(4'd0);
    n_chk++; if (drop !== 1'b0) $display("FAIL fp_drop got %0b want 0", drop); else n_pass++;
    n_chk++; if (wrap_total !== 8'd5) $display("FAIL fp_wrap got %0d want 5", wrap_total); else n_pass++;
    pops = 0;
    while (evt_valid === 1'b1 && pops < 10) begin
      tick(4'd0);
      pops++;
    end
    n_chk++; if (pops != 4) $display("FAIL fp_occupancy got %0d want 4", pops); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 1'b1; evt_ready = 1'b0; thresh = 4'd7;
    tick(4'd15);
    for (int i = 0; i < 3; i++) begin
      tick(4'd0);
      tick(4'd15);
    end
    n_chk++; if (evt_valid !== 1'b1) $display("FAIL rm_pre got %0b want 1", evt_valid); else n_pass++;
    #2 rst = 1'b0;
    model_clear();
    #1;
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL rm_valid got %0b want 0", evt_valid); else n_pass++;
    n_chk++; if (wrap_total !== 8'd0) $display("FAIL rm_wrap got %0d want 0", wrap_total); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick(4'd0);
    n_chk++; if (evt_valid !== 1'b0) $display("FAIL rm_first got %0b want 0", evt_valid); else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    mode = 1'b1; evt_ready = 1'b1; thresh = 4'd7;
    tick(4'd15);
    repeat (254) begin
      tick(4'd0);
      tick(4'd15);
    end
    n_chk++; if (wrap_total !== 8'd254) $display("FAIL sat_254 got %0d want 254", wrap_total); else n_pass++;
    repeat (6) begin
      tick(4'd0);
      tick(4'd15);
    end
    n_chk++; if (wrap_total !== 8'd255) $display("FAIL sat_255 got %0d want 255", wrap_total); else n_pass++;
  endtask

  task automatic test_random();
    int r;
    logic [3:0] c;
    do_reset();
    c = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 63) == 0) thresh = 4'($urandom_range(0, 15));
      evt_ready = $urandom_range(0, 2) != 0;
      r = $urandom_range(0, 9);
      c = (r == 3) ? c : (r == 4) ? thresh : (r == 5) ? 4'($urandom_range(0, 15)) : (mode ? c + 4'd1 : c - 4'd1);
      tick(c);
      n_chk++; if (evt_valid !== (m_q.size() > 0)) $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, evt_valid, m_q.size() > 0); else n_pass++;
      if (m_q.size() > 0) begin
        n_chk++; if ({evt_type, evt_count} !== m_q[0]) $display("FAIL rnd_head cyc %0d got %b want %b", i, {evt_type, evt_count}, m_q[0]); else n_pass++;
      end
      n_chk++; if (wrap_total !== 8'(m_wrap)) $display("FAIL rnd_wrap cyc %0d got %0d want %0d", i, wrap_total, m_wrap); else n_pass++;
      n_chk++; if (drop !== m_drop) $display("FAIL rnd_drop cyc %0d got %0b want %0b", i, drop, m_drop); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_threshold();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
